dbus_mem_responder: RTL and testbench
=====================================

Name: dbus_mem_responder

Overview:
- Responder (slave) end of the CPU data bus. The memory stage issues load/store requests as the initiator; this block answers them.
- Backed by an internal doubleword array with a configurable fixed latency. Used as the data-memory model in simulation and as an on-chip scratchpad.
- Implements the valid / addr_ok / data_ok handshake, byte-strobed writes, alignment checking and range checking.

Parameters:
- MEM_WORDS, 1024: number of 64-bit words in the array.
- BASE_ADDR, 64'h8000_0000: byte address mapped to word 0.
- LATENCY, 2: wait cycles between acceptance and response; legal range 1..15.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- req_valid  in  1  request present. The initiator holds it, and all req_* fields stable, until it sees data_ok.
- req_addr  in  64  byte address.
- req_size  in  3  access size: 0=1B, 1=2B, 2=4B, 3=8B; 4..7 illegal.
- req_strobe  in  8  byte-lane write enables; 0 means read, nonzero means write.
- req_data  in  64  write data, lane-aligned: byte i is on bits [8i+7:8i].
- resp_addr_ok  out  1  request accepted; pulses together with data_ok.
- resp_data_ok  out  1  one-cycle completion pulse.
- resp_data  out  64  full aligned doubleword at (req_addr & ~7) for reads; 0 for writes and errors.
- resp_err  out  1  valid only while data_ok is high: out-of-range, misaligned or illegal size.

Behaviour:
- Reset:
  - state=IDLE, counter=0, resp_addr_ok=0, resp_data_ok=0, resp_data=0, resp_err=0, latched request cleared.
  - Array contents are not cleared.
  - Reset in any state aborts the operation in flight: no memory write, no response pulse. The first cycle after reset deasserts is IDLE.
- FSM states:
  - IDLE: when req_valid=1 at an edge, latch addr/size/strobe/data, set counter=LATENCY-1, go to BUSY. Otherwise stay.
  - BUSY: when counter≠0, decrement. When counter=0, perform the access using the latched values, register resp_data and resp_err, go to RESP.
  - RESP: resp_addr_ok=resp_data_ok=1, driven from the state register. Go to IDLE at the next edge.
- Latency:
  - Request accepted at edge k gives data_ok high during the cycle following edge k+LATENCY.
  - data_ok is therefore high exactly LATENCY+1 cycles after the first cycle req_valid is seen.
  - Throughput is one transaction per LATENCY+2 cycles.
  - A request still held high in the RESP cycle is the old one and is not re-accepted. The next request is sampled in IDLE.
- Address decode:
  - off = addr − BASE_ADDR; idx = off[63:3].
  - In range iff addr ≥ BASE_ADDR and idx < MEM_WORDS.
- Alignment:
  - Aligned iff addr[size-1:0]=0 (size 0 is always aligned).
  - size>3 is an error.
- Error response (out of range, misaligned or illegal size): no write, resp_data=0, resp_err=1. A response is still given; the block never hangs.
- Write: on the BUSY→RESP edge, for each i with strobe[i]=1, mem[idx][8i+7:8i] ← data[8i+7:8i]. resp_data=0.
  - Strobe lanes are not cross-checked against size; the initiator is responsible.
- Read: resp_data ← mem[idx], i.e. the value after any earlier committed write. Read-after-write to the same word returns the new data.
- Outputs hold: resp_data and resp_err hold their values until the next RESP. Only the ok pulses are guaranteed to be one cycle.
- Protocol violation: if req_valid drops during BUSY, the transaction still completes using the latched values.
- Simultaneous events: reset wins over everything, including a RESP-cycle write commit. Commit happens on the BUSY→RESP edge, so reset during RESP does not undo an already committed write.

Test Plan:
- Reset with req_valid=1 held for 3 cycles, then released -> all outputs 0 during reset. First acceptance at the first edge after reset deasserts; with LATENCY=2, data_ok is high in the 3rd cycle after that edge.
- Write addr=0x8000_0008, strobe=0xFF, data=0x1122334455667788; then read 0x8000_0008 size=3 -> read returns 0x1122334455667788, resp_err=0. data_ok is a single-cycle pulse each time.
- Byte write to 0x8000_000B, size=0, strobe=0x08, data=0x00000000AA000000; then read 0x8000_0008 -> returns 0x11223344AA667788.
- Read 0x7FFF_FFF8 and read BASE+8*MEM_WORDS -> resp_err=1, resp_data=0, data_ok still pulses. A write to BASE+8*MEM_WORDS leaves word MEM_WORDS-1 unchanged.
- Misaligned: write 0x8000_0004 size=3, strobe=0xFF -> resp_err=1, memory unchanged (verified by read-back). size=5 -> resp_err=1.
- Reset asserted in BUSY of a write to 0x8000_0010 with data 0xDEAD -> no data_ok pulse; a later read of 0x8000_0010 returns the prior value. Back-to-back reads with valid held through RESP -> exactly one data_ok per request, spacing LATENCY+2 cycles.

Source files
------------

// File: rtl/dbus_mem_responder_if.sv
// rtl/dbus_mem_responder_if.sv - CPU data-bus request/response bundle
// Initiator drives req_*, responder drives resp_*.
interface dbus_mem_responder_if;
   logic        req_valid;
   logic [63:0] req_addr;
   logic [2:0]  req_size;
   logic [7:0]  req_strobe;
   logic [63:0] req_data;
   logic        resp_addr_ok;
   logic        resp_data_ok;
   logic [63:0] resp_data;
   logic        resp_err;

   modport master (
      output req_valid, req_addr, req_size, req_strobe, req_data,
      input  resp_addr_ok, resp_data_ok, resp_data, resp_err
   );

   modport slave (
      input  req_valid, req_addr, req_size, req_strobe, req_data,
      output resp_addr_ok, resp_data_ok, resp_data, resp_err
   );
endinterface

// File: rtl/dbus_mem_responder.sv
// rtl/dbus_mem_responder.sv - fixed-latency data-bus responder over a 64-bit word array
// Requests are latched in IDLE, completed after LATENCY wait cycles, and acknowledged in RESP.
module dbus_mem_responder #(
   parameter int          MEM_WORDS = 1024,
   parameter logic [63:0] BASE_ADDR = 64'h8000_0000,
   parameter int          LATENCY   = 2
) (
   input  logic                  clk,
   input  logic                  reset,
   dbus_mem_responder_if.slave   bus
);

   localparam int IDX_W = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      RESP = 2'd2
   } state_t;

   state_t      state;
   state_t      state_next;
   logic [3:0]  cnt;
   logic [63:0] lat_addr;
   logic [2:0]  lat_size;
   logic [7:0]  lat_strobe;
   logic [63:0] lat_data;
   logic [63:0] resp_data_q;
   logic        resp_err_q;

   logic [63:0] mem [MEM_WORDS];

   logic [63:0]      off;
   logic [IDX_W-1:0] mem_idx;
   logic             in_range;
   logic             aligned;
   logic             access_err;
   logic             is_write;
   logic             commit;
   logic             unused_off;

   assign off        = lat_addr - BASE_ADDR;
   assign mem_idx    = off[IDX_W+2:3];
   assign in_range   = (lat_addr >= BASE_ADDR) && (off[63:3] < 61'(MEM_WORDS));
   assign access_err = !in_range || !aligned;
   assign is_write   = (lat_strobe != 8'h00);
   assign commit     = (state == BUSY) && (cnt == 4'd0);
   assign unused_off = &{1'b0, off[2:0]};

   // Illegal sizes fold into the alignment failure so they share the error path.
   always_comb begin
      aligned = 1'b0;
      case (lat_size)
         3'd0:    aligned = 1'b1;
         3'd1:    aligned = (lat_addr[0] == 1'b0);
         3'd2:    aligned = (lat_addr[1:0] == 2'b00);
         3'd3:    aligned = (lat_addr[2:0] == 3'b000);
         default: aligned = 1'b0;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   always_comb begin
      state_next = state;
      case (state)
         IDLE:    if (bus.req_valid) state_next = BUSY;
         BUSY:    if (cnt == 4'd0) state_next = RESP;
         RESP:    state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         cnt         <= 4'd0;
         lat_addr    <= 64'd0;
         lat_size    <= 3'd0;
         lat_strobe  <= 8'd0;
         lat_data    <= 64'd0;
         resp_data_q <= 64'd0;
         resp_err_q  <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (bus.req_valid) begin
                  lat_addr   <= bus.req_addr;
                  lat_size   <= bus.req_size;
                  lat_strobe <= bus.req_strobe;
                  lat_data   <= bus.req_data;
                  cnt        <= 4'(LATENCY - 1);
               end
            end
            BUSY: begin
               if (cnt != 4'd0) begin
                  cnt <= cnt - 4'd1;
               end else begin
                  resp_err_q  <= access_err;
                  resp_data_q <= (access_err || is_write) ? 64'd0 : mem[mem_idx];
               end
            end
            default: ;
         endcase
      end
   end

   // Commit on the BUSY->RESP edge so a reset landing in RESP cannot undo it.
   always_ff @(posedge clk) begin
      if (!reset && commit && !access_err && is_write) begin
         for (int i = 0; i < 8; i++) begin
            if (lat_strobe[i]) mem[mem_idx][8*i +: 8] <= lat_data[8*i +: 8];
         end
      end
   end

   assign bus.resp_addr_ok = (state == RESP);
   assign bus.resp_data_ok = (state == RESP);
   assign bus.resp_data    = resp_data_q;
   assign bus.resp_err     = resp_err_q;

endmodule

// File: tb/tb_dbus_mem_responder.sv
// tb/tb_dbus_mem_responder.sv - directed self-checking bench for dbus_mem_responder
module tb_dbus_mem_responder;

   localparam int          LAT   = 2;
   localparam int          WORDS = 1024;
   localparam logic [63:0] BASE  = 64'h8000_0000;

   logic clk = 1'b0;
   logic reset;
   int   n_cmp = 0;
   int   n_bad = 0;

   dbus_mem_responder_if bus ();

   dbus_mem_responder #(
      .MEM_WORDS (WORDS),
      .BASE_ADDR (BASE),
      .LATENCY   (LAT)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus.slave)
   );

   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%016h expected 0x%016h", tag, got, exp);
      end
   endtask

   // Issue one request at a negedge and hold it until data_ok; checks the pulse is one cycle.
   task automatic do_req(input string tag, input logic [63:0] addr, input logic [2:0] size,
                         input logic [7:0] strobe, input logic [63:0] data,
                         output logic [63:0] rdata, output logic rerr, output int lat);
      bit seen = 0;
      bus.req_valid  = 1'b1;
      bus.req_addr   = addr;
      bus.req_size   = size;
      bus.req_strobe = strobe;
      bus.req_data   = data;
      lat   = 0;
      rdata = 64'd0;
      rerr  = 1'b0;
      for (int c = 1; c <= 40 && !seen; c++) begin
         @(negedge clk);
         if (bus.resp_data_ok) begin
            seen  = 1;
            lat   = c;
            rdata = bus.resp_data;
            rerr  = bus.resp_err;
            check_eq({tag, "_addr_ok"}, 64'(bus.resp_addr_ok), 64'd1);
         end
      end
      check_eq({tag, "_done"}, 64'(seen), 64'd1);
      bus.req_valid = 1'b0;
      @(negedge clk);
      check_eq({tag, "_pulse_1cyc"}, 64'(bus.resp_data_ok), 64'd0);
   endtask

   logic [63:0] rd;
   logic        er;
   int          lt;
   int          pulses;
   int          first_p;
   int          last_p;
   bit          bad_space;
   bit          any_ok;

   initial begin
      reset          = 1'b1;
      bus.req_valid  = 1'b1;
      bus.req_addr   = BASE;
      bus.req_size   = 3'd3;
      bus.req_strobe = 8'h00;
      bus.req_data   = 64'd0;

      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         check_eq("reset_outs", {bus.resp_data[60:0], bus.resp_addr_ok, bus.resp_data_ok, bus.resp_err}, 64'd0);
         check_eq("reset_data_hi", 64'(bus.resp_data[63:61]), 64'd0);
      end

      // Request still held as reset drops: accepted at the first edge after.
      reset = 1'b0;
      do_req("post_reset", BASE, 3'd3, 8'h00, 64'd0, rd, er, lt);
      check_eq("post_reset_lat", 64'(lt), 64'(LAT + 1));
      check_eq("post_reset_err", 64'(er), 64'd0);

      do_req("wr8", BASE + 64'h8, 3'd3, 8'hFF, 64'h1122_3344_5566_7788, rd, er, lt);
      check_eq("wr8_err", 64'(er), 64'd0);
      check_eq("wr8_data", rd, 64'd0);
      check_eq("wr8_lat", 64'(lt), 64'(LAT + 1));

      do_req("rd8", BASE + 64'h8, 3'd3, 8'h00, 64'd0, rd, er, lt);
      check_eq("rd8_data", rd, 64'h1122_3344_5566_7788);
      check_eq("rd8_err", 64'(er), 64'd0);
      check_eq("rd8_hold", bus.resp_data, 64'h1122_3344_5566_7788);

      do_req("wrb", BASE + 64'hB, 3'd0, 8'h08, 64'h0000_0000_AA00_0000, rd, er, lt);
      check_eq("wrb_err", 64'(er), 64'd0);
      do_req("rdb", BASE + 64'h8, 3'd3, 8'h00, 64'd0, rd, er, lt);
      check_eq("rdb_data", rd, 64'h1122_3344_AA66_7788);

      do_req("rd_below", 64'h7FFF_FFF8, 3'd3, 8'h00, 64'd0, rd, er, lt);
      check_eq("rd_below_err", 64'(er), 64'd1);
      check_eq("rd_below_data", rd, 64'd0);
      do_req("rd_above", BASE + 64'(8 * WORDS), 3'd3, 8'h00, 64'd0, rd, er, lt);
      check_eq("rd_above_err", 64'(er), 64'd1);
      check_eq("rd_above_data", rd, 64'd0);

      do_req("wr_last", BASE + 64'(8 * (WORDS - 1)), 3'd3, 8'hFF, 64'h0123_4567_89AB_CDEF, rd, er, lt);
      check_eq("wr_last_err", 64'(er), 64'd0);
      do_req("wr_above", BASE + 64'(8 * WORDS), 3'd3, 8'hFF, 64'hFFFF_FFFF_FFFF_FFFF, rd, er, lt);
      check_eq("wr_above_err", 64'(er), 64'd1);
      do_req("rd_last", BASE + 64'(8 * (WORDS - 1)), 3'd3, 8'h00, 64'd0, rd, er, lt);
      check_eq("rd_last_data", rd, 64'h0123_4567_89AB_CDEF);
      check_eq("rd_last_err", 64'(er), 64'd0);

      do_req("wr_w0", BASE, 3'd3, 8'hFF, 64'hCAFE_F00D_0BAD_BEEF, rd, er, lt);
      do_req("wr_mis", BASE + 64'h4, 3'd3, 8'hFF, 64'h5A5A_5A5A_5A5A_5A5A, rd, er, lt);
      check_eq("wr_mis_err", 64'(er), 64'd1);
      do_req("rd_w0", BASE, 3'd3, 8'h00, 64'd0, rd, er, lt);
      check_eq("rd_w0_data", rd, 64'hCAFE_F00D_0BAD_BEEF);
      do_req("rd_h_mis", BASE + 64'h1, 3'd1, 8'h00, 64'd0, rd, er, lt);
      check_eq("rd_h_mis_err", 64'(er), 64'd1);
      do_req("rd_w_ok", BASE + 64'h4, 3'd2, 8'h00, 64'd0, rd, er, lt);
      check_eq("rd_w_ok_err", 64'(er), 64'd0);
      check_eq("rd_w_ok_data", rd, 64'hCAFE_F00D_0BAD_BEEF);
      do_req("rd_sz5", BASE, 3'd5, 8'h00, 64'd0, rd, er, lt);
      check_eq("rd_sz5_err", 64'(er), 64'd1);
      check_eq("rd_sz5_data", rd, 64'd0);

      // Reset lands while the write is in BUSY: no pulse, no commit.
      do_req("wr_prior", BASE + 64'h10, 3'd3, 8'hFF, 64'h5555, rd, er, lt);
      bus.req_valid  = 1'b1;
      bus.req_addr   = BASE + 64'h10;
      bus.req_size   = 3'd3;
      bus.req_strobe = 8'hFF;
      bus.req_data   = 64'hDEAD;
      any_ok = 0;
      @(negedge clk);
      any_ok |= bus.resp_data_ok;
      reset         = 1'b1;
      bus.req_valid = 1'b0;
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         any_ok |= bus.resp_data_ok;
      end
      reset = 1'b0;
      for (int c = 0; c < 4; c++) begin
         @(negedge clk);
         any_ok |= bus.resp_data_ok;
      end
      check_eq("rst_busy_no_ok", 64'(any_ok), 64'd0);
      do_req("rd_prior", BASE + 64'h10, 3'd3, 8'h00, 64'd0, rd, er, lt);
      check_eq("rd_prior_data", rd, 64'h5555);

      // Valid held continuously: one pulse per request, LAT+2 apart.
      bus.req_valid  = 1'b1;
      bus.req_addr   = BASE + 64'h8;
      bus.req_size   = 3'd3;
      bus.req_strobe = 8'h00;
      pulses    = 0;
      first_p   = 0;
      last_p    = 0;
      bad_space = 0;
      for (int c = 1; c <= 3 * (LAT + 2); c++) begin
         @(negedge clk);
         if (bus.resp_data_ok) begin
            if (pulses == 0) first_p = c;
            else if (c - last_p != LAT + 2) bad_space = 1;
            last_p = c;
            pulses++;
         end
      end
      bus.req_valid = 1'b0;
      check_eq("b2b_count", 64'(pulses), 64'd3);
      check_eq("b2b_first", 64'(first_p), 64'(LAT + 1));
      check_eq("b2b_spacing", 64'(bad_space), 64'd0);
      check_eq("b2b_data", bus.resp_data, 64'h1122_3344_AA66_7788);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
